mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single main-memory port between the instruction cache (requester I) and the data cache (requester D).
- Sequences each cache miss: an optional write-back of the dirty victim block, then a refill read of the missing block.
- Returns the refill block to the granted cache with a one-cycle ack.
- Sits between the 2-way set-associative caches (10-bit address, 4-word/128-bit blocks) and main memory.

Parameters:
ADDR_W, 10, byte-address width
BLOCK_W, 128, block width in bits (4 x 32-bit words)
OFF_W, 4, block-offset bits, forced to zero on memory addresses

Ports:
clk  input  1  system clock
rst_n  input  1  reset, asynchronous, active-low
req_i  input  1  I-cache miss request; held until ack_i
dirty_i  input  1  I victim needs write-back
fill_addr_i  input  ADDR_W  I missing address
wb_addr_i  input  ADDR_W  I victim block address
wb_data_i  input  BLOCK_W  I victim block data
req_d  input  1  D-cache miss request; held until ack_d
dirty_d  input  1  D victim needs write-back
fill_addr_d  input  ADDR_W  D missing address
wb_addr_d  input  ADDR_W  D victim block address
wb_data_d  input  BLOCK_W  D victim block data
ack_i  output  1  one-cycle done pulse to I
ack_d  output  1  one-cycle done pulse to D
rdata  output  BLOCK_W  refill block; valid while ack_x is high
busy  output  1  transaction in progress (state != IDLE)
mem_req  output  1  memory access request
mem_we  output  1  1 = write-back, 0 = refill read
mem_addr  output  ADDR_W  block-aligned memory address
mem_wdata  output  BLOCK_W  write-back data
mem_rdata  input  BLOCK_W  memory read data
mem_ready  input  1  memory completes current access this cycle

Behaviour:
- Clock and reset: one clock, clk. Reset rst_n is asynchronous, active-low.
- Reset values: all outputs 0, state IDLE, round-robin pointer = I, latched request registers 0.
- FSM states: IDLE, WB, FILL, DONE.
- IDLE:
  - Samples req_i/req_d; if none, stays in IDLE.
  - Otherwise arbitrates round-robin: pointer names the preferred requester; a sole requester wins regardless of pointer.
  - Latches grant id, dirty, fill_addr, wb_addr and wb_data of the winner.
  - Goes to WB if dirty=1, else FILL.
- WB:
  - mem_req=1, mem_we=1, mem_addr={wb_addr[ADDR_W-1:OFF_W], 0}, mem_wdata=latched wb_data.
  - Waits for mem_ready=1, then goes to FILL.
- FILL:
  - mem_req=1, mem_we=0, mem_addr={fill_addr[ADDR_W-1:OFF_W], 0}.
  - On mem_ready=1, registers mem_rdata into rdata and goes to DONE.
- DONE:
  - ack of the granted requester is 1 for exactly one cycle; rdata is held.
  - Pointer moves to the other requester; next state is IDLE.
- Memory-side outputs are registered and derived from next state, so they are valid the first cycle of WB/FILL. mem_req drops in the same clock edge that mem_ready completes the final access.
- Latency, mem_ready=1 immediately: clean miss ack 2 cycles after the IDLE sample; dirty miss 3 cycles. Each wait cycle on mem_ready adds one cycle.
- Latched request values are used for the whole transaction; changes on the inputs after grant are ignored.
- mem_ready is ignored while mem_req=0.
- Requester handshake: the requester deasserts req on the edge it samples ack. IDLE after DONE therefore sees only new requests; at most one transaction is outstanding per requester.
- Simultaneous req_i and req_d: the pointer decides; the loser keeps req high and is served next. Neither requester starves (each waits at most one transaction).
- Reset mid-transaction: immediate return to IDLE and mem_req=0. An in-flight memory access is abandoned. The pointer resets to I.

Optional Feature:
- MEM_ARB_FIXED_PRIO_EN defined: D always wins simultaneous requests; the pointer register is not built.
- Undefined: round-robin as above.
- FSM and latency are identical in both cases.

Decomposition:
- Shared package mem_arb_pkg holds:
  - state enum (IDLE/WB/FILL/DONE, 2 bits)
  - requester id constants REQ_I=0, REQ_D=1
  - ADDR_W/BLOCK_W/OFF_W defaults
- One natural sub-module: rr_arbiter2 (2-input round-robin or fixed-priority picker, combinational grant plus registered pointer update on DONE).

Test Plan:
- Clean I miss: req_i=1, dirty_i=0, fill_addr_i=10'h2A7, mem_ready tied 1, mem_rdata=128'hA5..A5 -> one FILL cycle with mem_addr=10'h2A0, mem_we=0; ack_i pulses 2 cycles after the sample; rdata=128'hA5..A5; ack_d stays 0.
- Dirty D miss: req_d=1, dirty_d=1, wb_addr_d=10'h157, wb_data_d=128'h1234, fill_addr_d=10'h3C4, mem_ready after 3 wait cycles per access -> write mem_addr=10'h150, mem_wdata=128'h1234; then read mem_addr=10'h3C0; ack_d at cycle 9.
- Simultaneous req_i and req_d from reset, both clean -> I served first, then D (pointer=I at reset); second simultaneous pair -> I first again. With MEM_ARB_FIXED_PRIO_EN -> D first both times.
- Reset mid-WB: rst_n=0 while in WB waiting -> mem_req, busy and ack go 0 asynchronously; after release, a D request is granted normally with the pointer at I.
- Input disturbance: mem_ready pulsed in IDLE -> no state change. fill_addr_i changed to 10'h0F0 during FILL -> mem_addr keeps the latched value.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared types and constants for the I/D cache memory port arbiter.
package mem_arb_pkg;
  localparam int ADDR_W  = 10;
  localparam int BLOCK_W = 128;
  localparam int OFF_W   = 4;

  localparam logic REQ_I = 1'b0;
  localparam logic REQ_D = 1'b1;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WB   = 2'd1,
    FILL = 2'd2,
    DONE = 2'd3
  } arb_state_e;

  function automatic logic [ADDR_W-1:0] block_addr(input logic [ADDR_W-1:0] a);
    return {a[ADDR_W-1:OFF_W], {OFF_W{1'b0}}};
  endfunction
endpackage

// File: rtl/mem_port_arbiter_if.sv
// Cache-side and memory-side signals of the memory port arbiter; slave = arbiter view.
interface mem_port_arbiter_if;
  import mem_arb_pkg::*;

  logic               req_i;
  logic               dirty_i;
  logic [ADDR_W-1:0]  fill_addr_i;
  logic [ADDR_W-1:0]  wb_addr_i;
  logic [BLOCK_W-1:0] wb_data_i;
  logic               req_d;
  logic               dirty_d;
  logic [ADDR_W-1:0]  fill_addr_d;
  logic [ADDR_W-1:0]  wb_addr_d;
  logic [BLOCK_W-1:0] wb_data_d;
  logic               ack_i;
  logic               ack_d;
  logic [BLOCK_W-1:0] rdata;
  logic               busy;
  logic               mem_req;
  logic               mem_we;
  logic [ADDR_W-1:0]  mem_addr;
  logic [BLOCK_W-1:0] mem_wdata;
  logic [BLOCK_W-1:0] mem_rdata;
  logic               mem_ready;

  modport slave (
    input  req_i, dirty_i, fill_addr_i, wb_addr_i, wb_data_i,
    input  req_d, dirty_d, fill_addr_d, wb_addr_d, wb_data_d,
    output ack_i, ack_d, rdata, busy,
    output mem_req, mem_we, mem_addr, mem_wdata,
    input  mem_rdata, mem_ready
  );

  modport master (
    output req_i, dirty_i, fill_addr_i, wb_addr_i, wb_data_i,
    output req_d, dirty_d, fill_addr_d, wb_addr_d, wb_data_d,
    input  ack_i, ack_d, rdata, busy,
    input  mem_req, mem_we, mem_addr, mem_wdata,
    output mem_rdata, mem_ready
  );
endinterface

// File: rtl/rr_arbiter2.sv
// Two-requester picker for the memory port: round-robin by default,
// fixed D priority (no pointer register) when MEM_ARB_FIXED_PRIO_EN is defined.
module rr_arbiter2
  import mem_arb_pkg::*;
(
  input  logic clk,
  input  logic rst_n,
  input  logic req_i,
  input  logic req_d,
  input  logic advance,
  input  logic last_id,
  output logic grant_id
);
`ifdef MEM_ARB_FIXED_PRIO_EN
  logic unused_rr;
  assign unused_rr = ^{clk, rst_n, req_i, advance, last_id};
  assign grant_id  = req_d ? REQ_D : REQ_I;
`else
  logic ptr;

  // pointer names the preferred requester; after a grant it moves to the other one
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ptr <= REQ_I;
    else if (advance) ptr <= ~last_id;
  end

  assign grant_id = (req_i && req_d) ? ptr : (req_d ? REQ_D : REQ_I);
`endif
endmodule

// File: rtl/mem_port_arbiter.sv
// Serialises I/D cache misses onto one memory port: optional victim write-back, then refill.
// Build option MEM_ARB_FIXED_PRIO_EN: D always wins ties instead of round-robin.
module mem_port_arbiter
  import mem_arb_pkg::*;
(
  input logic               clk,
  input logic               rst_n,
  mem_port_arbiter_if.slave bus
);
  // state | meaning
  // IDLE  | waiting for a miss request
  // WB    | writing the dirty victim block back
  // FILL  | reading the missing block
  // DONE  | one-cycle ack to the granted requester

  arb_state_e         state, nxt;
  logic               gnt_id, gnt_q, id_sel, win_dirty, any_req;
  logic [ADDR_W-1:0]  fill_addr_q, wb_addr_q, fill_sel, wb_sel, mem_addr_q;
  logic [BLOCK_W-1:0] wb_data_q, wb_data_sel, rdata_q, mem_wdata_q;
  logic               mem_req_q, mem_we_q, ack_i_q, ack_d_q;

  assign any_req = bus.req_i | bus.req_d;

  rr_arbiter2 u_arb (
    .clk      (clk),
    .rst_n    (rst_n),
    .req_i    (bus.req_i),
    .req_d    (bus.req_d),
    .advance  (state == DONE),
    .last_id  (gnt_q),
    .grant_id (gnt_id)
  );

  // In IDLE the winner's live inputs feed the registered outputs; afterwards only the latched copy
  always_comb begin
    win_dirty = (gnt_id == REQ_D) ? bus.dirty_d : bus.dirty_i;
    if (state == IDLE) begin
      id_sel      = gnt_id;
      fill_sel    = (gnt_id == REQ_D) ? bus.fill_addr_d : bus.fill_addr_i;
      wb_sel      = (gnt_id == REQ_D) ? bus.wb_addr_d   : bus.wb_addr_i;
      wb_data_sel = (gnt_id == REQ_D) ? bus.wb_data_d   : bus.wb_data_i;
    end else begin
      id_sel      = gnt_q;
      fill_sel    = fill_addr_q;
      wb_sel      = wb_addr_q;
      wb_data_sel = wb_data_q;
    end
  end

  always_comb begin
    nxt = state;
    case (state)
      IDLE:    if (any_req) nxt = win_dirty ? WB : FILL;
      WB:      if (bus.mem_ready) nxt = FILL;
      FILL:    if (bus.mem_ready) nxt = DONE;
      DONE:    nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state       <= IDLE;
      gnt_q       <= REQ_I;
      fill_addr_q <= '0;
      wb_addr_q   <= '0;
      wb_data_q   <= '0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= '0;
      mem_wdata_q <= '0;
      rdata_q     <= '0;
      ack_i_q     <= 1'b0;
      ack_d_q     <= 1'b0;
    end else begin
      state <= nxt;
      if (state == IDLE && any_req) begin
        gnt_q       <= id_sel;
        fill_addr_q <= fill_sel;
        wb_addr_q   <= wb_sel;
        wb_data_q   <= wb_data_sel;
      end
      mem_req_q   <= (nxt == WB) || (nxt == FILL);
      mem_we_q    <= (nxt == WB);
      mem_addr_q  <= (nxt == WB)   ? block_addr(wb_sel) :
                     (nxt == FILL) ? block_addr(fill_sel) : '0;
      mem_wdata_q <= (nxt == WB) ? wb_data_sel : '0;
      if (state == FILL && bus.mem_ready) rdata_q <= bus.mem_rdata;
      ack_i_q     <= (nxt == DONE) && (id_sel == REQ_I);
      ack_d_q     <= (nxt == DONE) && (id_sel == REQ_D);
    end
  end

  assign bus.mem_req   = mem_req_q;
  assign bus.mem_we    = mem_we_q;
  assign bus.mem_addr  = mem_addr_q;
  assign bus.mem_wdata = mem_wdata_q;
  assign bus.rdata     = rdata_q;
  assign bus.ack_i     = ack_i_q;
  assign bus.ack_d     = ack_d_q;
  assign bus.busy      = (state != IDLE);
endmodule
